spi_status_tx: RTL and testbench

SPI slave transmitter that returns a 16-bit status word from the ice40 to the samd51 on `cfg_so` while the samd51 clocks a frame on `cfg_cs`/`cfg_sck`. It is the FPGA→MCU direction of the same SPI link whose MCU→FPGA receiver delivers note/amplitude words to the synth. Fabric logic hands it words through a one-entry holding register with a valid/ready handshake. All SPI inputs are oversampled in the 48 MHz `clk` domain.

---
 rtl/doppler_spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_status_tx.sv | 153 +++++++++++++++
 tb/tb_spi_status_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/doppler_spi_pkg.sv
// Shared definitions for the ice40 <-> samd51 SPI link (receiver and status transmitter).
package doppler_spi_pkg;

  localparam int SPI_WIDTH       = 16;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes one asynchronous SPI pin into clk and produces single-cycle edge strobes.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Chain resets low so a pin already held low after reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_status_tx.sv
// SPI mode-0 slave transmitter returning a status word to the MCU, fed by a one-entry holding register.
//
// state | meaning
// IDLE  | deselected, cfg_so released, waiting for CS to fall
// SHIFT | selected, shifting out the frame word MSB first
// HOLD  | all WIDTH bits sent, shifting zeros until CS rises
module spi_status_tx
  import doppler_spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             cfg_cs,
  input  logic             cfg_sck,
  output logic             cfg_so,
  output logic             cfg_so_oe,
  output logic             word_sent,
  output logic             underrun,
  output logic             aborted
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic unused_levels;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (cfg_cs),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (cfg_sck),
    .level    (sck_level),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  assign unused_levels = cs_level ^ sck_level;

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic             underrun_frame_q, underrun_frame_d;
  logic             word_sent_q, word_sent_d;
  logic             underrun_q, underrun_d;
  logic             aborted_q, aborted_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      shift_q          <= '0;
      hold_q           <= '0;
      hold_full_q      <= 1'b0;
      bitcnt_q         <= '0;
      underrun_frame_q <= 1'b0;
      word_sent_q      <= 1'b0;
      underrun_q       <= 1'b0;
      aborted_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      shift_q          <= shift_d;
      hold_q           <= hold_d;
      hold_full_q      <= hold_full_d;
      bitcnt_q         <= bitcnt_d;
      underrun_frame_q <= underrun_frame_d;
      word_sent_q      <= word_sent_d;
      underrun_q       <= underrun_d;
      aborted_q        <= aborted_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    hold_d           = hold_q;
    hold_full_d      = hold_full_q;
    bitcnt_d         = bitcnt_q;
    underrun_frame_d = underrun_frame_q;
    word_sent_d      = 1'b0;
    underrun_d       = 1'b0;
    aborted_d        = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
          // A word arriving in this same cycle only lands in the holding register.
          if (hold_full_q) begin
            shift_d          = hold_q;
            hold_full_d      = 1'b0;
            underrun_frame_d = 1'b0;
          end else begin
            shift_d          = IDLE_WORD;
            underrun_d       = 1'b1;
            underrun_frame_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          if (sck_rise) begin
            if (bitcnt_q != CNT_FULL) bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_LAST) begin
              state_d     = HOLD;
              word_sent_d = !underrun_frame_q;
            end
          end
          if (sck_fall) shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
      end
      HOLD: begin
        if (cs_rise) state_d = IDLE;
        else if (sck_fall) shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready  = !hold_full_q;
  assign cfg_so_oe = (state_q != IDLE);
  assign cfg_so    = (state_q != IDLE) & shift_q[WIDTH-1];
  assign word_sent = word_sent_q;
  assign underrun  = underrun_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_spi_status_tx.sv
// Directed and randomized frames for spi_status_tx against a word-level model of the holding register and frame.
module tb_spi_status_tx;

  localparam int W  = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          cfg_cs;
  logic          cfg_sck;
  logic          cfg_so;
  logic          cfg_so_oe;
  logic          word_sent;
  logic          underrun;
  logic          aborted;

  spi_status_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .cfg_cs    (cfg_cs),
    .cfg_sck   (cfg_sck),
    .cfg_so    (cfg_so),
    .cfg_so_oe (cfg_so_oe),
    .word_sent (word_sent),
    .underrun  (underrun),
    .aborted   (aborted)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ws_cnt   = 0;
  int ur_cnt   = 0;
  int ab_cnt   = 0;

  always @(negedge clk) begin
    if (word_sent === 1'b1) ws_cnt++;
    if (underrun  === 1'b1) ur_cnt++;
    if (aborted   === 1'b1) ab_cnt++;
  end

  // Model: holding register contents.
  bit           m_hold_valid = 1'b0;
  logic [W-1:0] m_hold_word  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] w, input string tag);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = $urandom;
    if (!m_hold_valid) begin
      m_hold_valid = 1'b1;
      m_hold_word  = w;
    end
    check({tag, "_ready"}, 32'(tx_ready), 32'(!m_hold_valid));
  endtask

  // One master frame: CS low, nbits SCK pulses with half period h clk cycles, CS high.
  task automatic run_frame(input int nbits, input int h, input bit coincide,
                           input logic [W-1:0] cword, input string tag);
    logic [W-1:0] src;
    bit           exp_ur;
    logic [31:0]  got, exp;
    int           ws0, ur0, ab0;
    ws0 = ws_cnt; ur0 = ur_cnt; ab0 = ab_cnt;
    exp_ur = !m_hold_valid;
    src    = m_hold_valid ? m_hold_word : '0;
    m_hold_valid = 1'b0;

    @(negedge clk);
    cfg_cs = 1'b0;
    if (coincide) begin
      repeat (SS) @(negedge clk);
      tx_data  = cword;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      if (!m_hold_valid) begin
        m_hold_valid = 1'b1;
        m_hold_word  = cword;
      end
      repeat (h - SS - 1) @(negedge clk);
    end else begin
      repeat (h) @(negedge clk);
    end
    check({tag, "_oe_on"}, 32'(cfg_so_oe), 32'd1);
    check({tag, "_ready_start"}, 32'(tx_ready), 32'(!m_hold_valid));

    got = '0;
    exp = '0;
    for (int i = 0; i < nbits; i++) begin
      got = {got[30:0], cfg_so};
      exp = {exp[30:0], (i < W) ? src[W-1-i] : 1'b0};
      cfg_sck = 1'b1;
      repeat (h) @(negedge clk);
      cfg_sck = 1'b0;
      repeat (h) @(negedge clk);
    end
    cfg_cs = 1'b1;
    repeat (SS + 4) @(negedge clk);

    check({tag, "_bits"}, got, exp);
    check({tag, "_oe_off"}, 32'(cfg_so_oe), 32'd0);
    check({tag, "_word_sent"}, 32'(ws_cnt - ws0), 32'((nbits >= W && !exp_ur) ? 1 : 0));
    check({tag, "_underrun"}, 32'(ur_cnt - ur0), 32'(exp_ur ? 1 : 0));
    check({tag, "_aborted"}, 32'(ab_cnt - ab0), 32'((nbits < W) ? 1 : 0));
  endtask

  initial begin
    int ws0, ur0, ab0;
    rst_n    = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    cfg_cs   = 1'b1;
    cfg_sck  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_so", 32'(cfg_so), 32'd0);
    check("rst_so_oe", 32'(cfg_so_oe), 32'd0);
    check("rst_pulses", 32'({word_sent, underrun, aborted}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Full frame of a loaded word.
    load(16'hA5C3, "a5c3_load");
    run_frame(16, 6, 1'b0, '0, "a5c3");

    // No word loaded.
    run_frame(16, 6, 1'b0, '0, "empty");

    // Abort after 7 bits, then the dropped word is not re-sent.
    load(16'h1234, "abort_load");
    run_frame(7, 6, 1'b0, '0, "abort");
    run_frame(16, 6, 1'b0, '0, "after_abort");

    // Over-long frame; a second load while full must be ignored.
    load(16'hFFFF, "ffff_load");
    load(16'h1111, "ffff_blocked");
    run_frame(20, 6, 1'b0, '0, "ffff20");

    // Handshake lands on the cs_fall cycle with holding empty.
    run_frame(16, 6, 1'b1, 16'h00FF, "coinc");
    run_frame(16, 6, 1'b0, '0, "coinc_next");

    // Reset mid-frame with CS held low.
    load(16'h5A5A, "rst_load");
    @(negedge clk);
    cfg_cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cfg_sck = 1'b1; repeat (6) @(negedge clk);
      cfg_sck = 1'b0; repeat (6) @(negedge clk);
    end
    check("mid_oe_before_rst", 32'(cfg_so_oe), 32'd1);
    ws0 = ws_cnt; ur0 = ur_cnt; ab0 = ab_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(cfg_so_oe), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    m_hold_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_sck = 1'b1; repeat (6) @(negedge clk);
      cfg_sck = 1'b0; repeat (6) @(negedge clk);
    end
    check("post_rst_oe_cs_low", 32'(cfg_so_oe), 32'd0);
    cfg_cs = 1'b1;
    repeat (SS + 4) @(negedge clk);
    check("post_rst_no_pulses", 32'((ws_cnt - ws0) + (ur_cnt - ur0) + (ab_cnt - ab0)), 32'd0);
    load(16'h0F0F, "post_rst_load");
    run_frame(16, 6, 1'b0, '0, "post_rst");

    // Randomized frames against the model.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) load(W'($urandom), "rnd_load");
      run_frame(int'($urandom_range(1, 20)), int'($urandom_range(6, 9)), 1'b0, '0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
